// File: rtl/leb128_window_if.sv
// leb128_window_if: byte input stream and window output stream
// for the LEB128 windowing front end.
interface leb128_window_if;
    logic [7:0]  s_data;
    logic        s_valid;
    logic        s_ready;
    logic [71:0] win;
    logic [3:0]  win_len;
    logic        win_valid;
    logic        win_ready;
    logic        err;

    modport master (
        output s_data, s_valid, win_ready,
        input  s_ready, win, win_len, win_valid, err
    );

    modport slave (
        input  s_data, s_valid, win_ready,
        output s_ready, win, win_len, win_valid, err
    );
endinterface

// File: rtl/leb128_window.sv
// leb128_window: buffers LEB128 bytes and presents a 9-byte window
// aligned to the next value. Optional: LEB128_WINDOW_ERR_EN (sticky err).
module leb128_window #(
    parameter int DEPTH = 16
) (
    input logic            clk,
    input logic            rst,
    leb128_window_if.slave bus
);
    localparam int CW = $clog2(DEPTH + 1);

    logic [7:0]    mem_q [DEPTH];
    logic [7:0]    mem_d [DEPTH];
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    logic          found;
    logic [3:0]    term_idx;
    logic          win_valid_c;
    logic [3:0]    win_len_c;
    logic [71:0]   win_c;
    logic          s_ready_c;
    logic          push;
    logic          pop;
    int            cnt_i;
    int            pop_n;
    int            wr_idx;
    int            src;

    // Terminator search and window assembly from registered state.
    always_comb begin
        cnt_i    = int'(cnt_q);
        found    = 1'b0;
        term_idx = 4'd0;
        win_c    = '0;
        for (int k = 0; k < 9; k++) begin
            if (k < cnt_i) begin
                win_c[8*k +: 8] = mem_q[k];
                if (!found && !mem_q[k][7]) begin
                    found    = 1'b1;
                    term_idx = 4'(k);
                end
            end
        end
        win_valid_c = !rst && (found || cnt_i >= 9);
        if (!win_valid_c)
            win_len_c = 4'd0;
        else if (found)
            win_len_c = term_idx + 4'd1;
        else
            win_len_c = 4'd9;
        if (rst)
            win_c = '0;
        s_ready_c = !rst && (cnt_i < DEPTH);
    end

    // Next buffer contents: shift out the consumed value, append input.
    always_comb begin
        push   = bus.s_valid && s_ready_c;
        pop    = win_valid_c && bus.win_ready;
        pop_n  = pop ? int'(win_len_c) : 0;
        wr_idx = cnt_i - pop_n;
        src    = 0;
        for (int i = 0; i < DEPTH; i++) begin
            src = i + pop_n;
            if (src < DEPTH)
                mem_d[i] = mem_q[src];
            else
                mem_d[i] = 8'h00;
            if (push && i == wr_idx)
                mem_d[i] = bus.s_data;
        end
        cnt_d = CW'(cnt_i - pop_n + (push ? 1 : 0));
    end

    // Buffer and occupancy registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++)
                mem_q[i] <= 8'h00;
        end else begin
            cnt_q <= cnt_d;
            mem_q <= mem_d;
        end
    end

    assign bus.s_ready   = s_ready_c;
    assign bus.win_valid = win_valid_c;
    assign bus.win_len   = win_len_c;
    assign bus.win       = win_c;

`ifdef LEB128_WINDOW_ERR_EN
    logic err_q;
    logic err_d;

    // Overlong consumed: a window popped with no terminator in 9 bytes.
    always_comb begin
        err_d = err_q | (pop && !found);
    end

    // Sticky error flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst)
            err_q <= 1'b0;
        else
            err_q <= err_d;
    end

    assign bus.err = err_q;
`else
    assign bus.err = 1'b0;
`endif
endmodule
